// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================================
// branch_resolve_unit_pkg : shared opcodes, func3 codes and predictor encodings
// Revision 1.0
// ============================================================================
`default_nettype none

package branch_resolve_unit_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  // Saturating 2-bit counter step
  function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
    bht_cnt_e nxt;
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_bht_table.sv
// ============================================================================
// bht_table : 2-bit counter array, one combinational read port, one update port
// Revision 1.0
// ============================================================================
`default_nettype none

module bht_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_cnt_e cnt_q [DEPTH];

  // Read sees the stored value only; a same-cycle write is not forwarded
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= WNT;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= bht_next(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit : EX branch compare/decode, bimodal predictor, statistics
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             if_pred_taken_o,
  input  logic             ex_valid_i,
  input  logic [6:0]       ex_op_i,
  input  logic [2:0]       ex_func3_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             ex_pred_taken_i,
  input  logic [XLEN-1:0]  src1_i,
  input  logic [XLEN-1:0]  src2_i,
  output logic [XLEN-1:0]  src1_o,
  output logic [XLEN-1:0]  src2_o,
  output logic             take_branch_o,
  output logic             mispredict_o,
  output logic             illegal_br_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mp_count_o
);

  localparam int IDX = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             is_branch;
  logic             legal_br;
  logic             cmp_taken;
  logic [1:0]       rd_cnt;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic             unused_pc_bits;

  assign src1_o = src1_i;
  assign src2_o = src2_i;

  assign is_branch = ex_valid_i && (ex_op_i == OP_BRANCH);

  always_comb begin
    cmp_taken    = 1'b0;
    illegal_br_o = 1'b0;
    unique case (ex_func3_i)
      F3_BEQ:  cmp_taken = (src1_i == src2_i);
      F3_BNE:  cmp_taken = (src1_i != src2_i);
      F3_BLT:  cmp_taken = ($signed(src1_i) <  $signed(src2_i));
      F3_BGE:  cmp_taken = ($signed(src1_i) >= $signed(src2_i));
      F3_BLTU: cmp_taken = (src1_i <  src2_i);
      F3_BGEU: cmp_taken = (src1_i >= src2_i);
      default: illegal_br_o = is_branch;
    endcase
  end

  assign legal_br      = is_branch && !illegal_br_o;
  assign take_branch_o = legal_br && cmp_taken;
  assign mispredict_o  = legal_br && (cmp_taken != ex_pred_taken_i);

  bht_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (if_pc_i[IDX+1:2]),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (legal_br),
    .wr_idx_i   (ex_pc_i[IDX+1:2]),
    .wr_taken_i (cmp_taken)
  );

  assign if_pred_taken_o = rd_cnt[1];

  // Statistics saturate at all-ones rather than wrapping
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (legal_br) begin
      if (!(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_ONE;
      if (mispredict_o && !(&mp_cnt_q)) mp_cnt_d = mp_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign br_count_o = br_cnt_q;
  assign mp_count_o = mp_cnt_q;

  assign unused_pc_bits = ^{if_pc_i[XLEN-1:IDX+2], if_pc_i[1:0],
                            ex_pc_i[XLEN-1:IDX+2], ex_pc_i[1:0]};

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits.
REQ-002 Parameter BHT_DEPTH, default 64, number of 2-bit predictor entries; power of 2, at least 4.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 if_pc  in  XLEN  fetch-stage PC used for the prediction lookup.
REQ-007 if_pred_taken  out  1  prediction for if_pc: MSB of the indexed counter.
REQ-008 ex_valid  in  1  EX-stage instruction valid qualifier.
REQ-009 ex_op  in  7  EX opcode.
REQ-010 ex_func3  in  3  EX func3.
REQ-011 ex_pc  in  XLEN  PC of the EX-stage instruction.
REQ-012 ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction.
REQ-013 src1, src2  in  XLEN each  forwarded operands.
REQ-014 src1_out, src2_out  out  XLEN each  operands passed through unchanged.
REQ-015 take_branch  out  1  resolved branch direction.
REQ-016 mispredict  out  1  asserted when resolved direction differs from ex_pred_taken; drives the pipeline flush.
REQ-017 illegal_br  out  1  branch opcode with reserved func3 (010 or 011).
REQ-018 br_count, mp_count  out  CNT_W each  counts of resolved branches and of mispredicts.

Function
REQ-019 An EX branch is defined as ex_valid=1 and ex_op=1100011.
REQ-020 take_branch, mispredict and illegal_br shall be combinational from the EX inputs, with zero-cycle latency.
REQ-021 func3 decode for take_branch:
  - 000: EQ
  - 001: NE
  - 100: signed LT
  - 101: signed GE
  - 110: unsigned LT
  - 111: unsigned GE
  - All comparisons are XLEN bits wide.
REQ-022 For a non-branch, or for ex_valid=0: take_branch=0, mispredict=0, illegal_br=0.
REQ-023 For reserved func3 (010, 011): take_branch=0, illegal_br=1, mispredict=0; no BHT update and no counter update.
REQ-024 mispredict shall equal take_branch XOR ex_pred_taken for every legal EX branch.
REQ-025 Index width is IDX=log2(BHT_DEPTH); the index is pc[IDX+1:2], with bits [1:0] ignored.
REQ-026 if_pred_taken shall be combinational from if_pc and the current BHT contents.
REQ-027 On each legal EX branch, the indexed 2-bit counter shall update at the clock edge: increment when taken, decrement when not taken, saturating at 11 and 00.
REQ-028 When the fetch lookup and the EX update hit the same index in the same cycle, if_pred_taken shall reflect the pre-update value; there is no bypass.
REQ-029 br_count shall increment by 1 per legal EX branch, and mp_count by 1 per mispredict, both saturating at all-ones with no wrap.
REQ-030 The unit shall keep no other state; there is no stall or handshake, and ex_valid alone qualifies updates.

Reset
REQ-031 While rst_n=0, every BHT entry shall be 01 (weakly not-taken) and br_count=mp_count=0, taking effect immediately without waiting for clk.
REQ-032 Therefore if_pred_taken=0 for any if_pc during and immediately after reset.
REQ-033 Combinational outputs are unaffected by reset other than through BHT state.
REQ-034 A branch presented in the cycle rst_n deasserts shall be resolved combinationally, but shall update state only at the first rising edge where rst_n=1.

Structure
REQ-035 A shared package shall hold:
  - OP_BRANCH = 1100011
  - the func3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - the 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11)
REQ-036 One sub-module, bht_table, shall hold the counter array:
  - one combinational read port
  - one update port
  - asynchronous reset
REQ-037 Comparison, decode and statistics logic shall reside in the top module.

Verification
REQ-038 Reset, then if_pc=0x100 -> if_pred_taken=0, and br_count=mp_count=0.
REQ-039 BLT with src1=0xFFFFFFFF, src2=1, ex_pred_taken=0 -> take_branch=1, mispredict=1; after the edge, mp_count=1.
REQ-040 BLTU with the same operands -> take_branch=0, mispredict=0.
REQ-041 Four taken BEQ at ex_pc=0x40 -> counter reaches 11, with if_pred_taken=1 at if_pc=0x40 from the first update onward; one not-taken -> counter 10, prediction still 1.
REQ-042 Same-cycle EX update and fetch lookup at index 0x10 -> if_pred_taken shows the old value, then the new value next cycle.
REQ-043 func3=010 with ex_valid=1 -> illegal_br=1, take_branch=0, and no counter change; with CNT_W=4, 20 mispredicts -> mp_count holds at 0xF.
